// File: rtl/systolic_pkg.sv
// -----------------------------------------------------------------------------
// systolic_pkg
// Shared constants, drain state encoding and the int8 requantize helper used
// by systolic_result_drain and its requant_lane instances.
// -----------------------------------------------------------------------------
package systolic_pkg;

   localparam int ARRAY_SIZE      = 32;
   localparam int DATA_WIDTH      = 18;
   localparam int OUTCOME_WIDTH   = 2*DATA_WIDTH + 5;
   localparam int SRAM_DATA_WIDTH = 64;
   localparam int ADDR_WIDTH      = 10;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      WRITE   = 2'd2
   } drain_state_e;

   // Round-half-up arithmetic shift, optional ReLU, then saturate to int8.
   // One extra bit of headroom keeps the rounding add from overflowing.
   function automatic logic [7:0] requant_sat8(
      input logic signed [OUTCOME_WIDTH-1:0] v,
      input logic        [4:0]               shift,
      input logic                            relu
   );
      logic signed [OUTCOME_WIDTH:0] ext_s;
      logic signed [OUTCOME_WIDTH:0] rnd_s;
      logic signed [OUTCOME_WIDTH:0] t_s;
      logic        [7:0]             q_s;
      ext_s = {v[OUTCOME_WIDTH-1], v};
      rnd_s = '0;
      if (shift != 5'd0) begin
         rnd_s[shift - 5'd1] = 1'b1;
         t_s = (ext_s + rnd_s) >>> shift;
      end else begin
         t_s = ext_s;
      end
      if (relu && t_s[OUTCOME_WIDTH]) begin
         t_s = '0;
      end else begin
         t_s = t_s;
      end
      if (t_s > 42'sd127) begin
         q_s = 8'h7F;
      end else if (t_s < -42'sd128) begin
         q_s = 8'h80;
      end else begin
         q_s = t_s[7:0];
      end
      return q_s;
   endfunction

endpackage

// File: rtl/requant_lane.sv
// -----------------------------------------------------------------------------
// requant_lane
// Combinational requantization of one accumulator lane to int8.
//   v           : 41-bit signed accumulator
//   shift       : arithmetic right shift with round-half-up
//   relu_en     : clamp negative results to zero
//   result_byte : saturated int8 result
// -----------------------------------------------------------------------------
module requant_lane
   import systolic_pkg::*;
(
   input  logic [OUTCOME_WIDTH-1:0] v,
   input  logic [4:0]               shift,
   input  logic                     relu_en,
   output logic [7:0]               result_byte
);

   // Pure function of the lane value and the latched requant settings.
   always_comb begin
      result_byte = requant_sat8($signed(v), shift, relu_en);
   end

endmodule

// File: rtl/systolic_result_drain.sv
// -----------------------------------------------------------------------------
// systolic_result_drain
// Drains a finished 32x32 systolic tile: walks matrix_index 0..31, requantizes
// the 32 result lanes each cycle into a 32x32 int8 buffer, then streams the
// buffer row-major as 64-bit words over a valid/ready write port.
//   clk, rst      : clock, synchronous active-high reset
//   start         : pulse, tile ready; latches shift_amt, relu_en, base_addr
//   matrix_index  : result select driven to the array (registered)
//   mul_outcome   : 32 lanes x 41 bits, read combinationally during capture
//   wr_valid/wr_ready/wr_addr/wr_data : output SRAM write port
//   busy          : drain in progress
//   done          : one-cycle pulse after the final word is accepted
// -----------------------------------------------------------------------------
module systolic_result_drain
   import systolic_pkg::*;
(
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                start,
   input  logic [4:0]                          shift_amt,
   input  logic                                relu_en,
   input  logic [ADDR_WIDTH-1:0]               base_addr,
   output logic [5:0]                          matrix_index,
   input  logic [ARRAY_SIZE*OUTCOME_WIDTH-1:0] mul_outcome,
   output logic                                wr_valid,
   input  logic                                wr_ready,
   output logic [ADDR_WIDTH-1:0]               wr_addr,
   output logic [SRAM_DATA_WIDTH-1:0]          wr_data,
   output logic                                busy,
   output logic                                done
);

   drain_state_e                 state_r;
   logic [4:0]                   cap_k_r;
   logic [6:0]                   beat_r;
   logic [4:0]                   shift_r;
   logic                         relu_r;
   logic [ADDR_WIDTH-1:0]        base_r;
   logic                         wr_valid_r;
   logic [ADDR_WIDTH-1:0]        wr_addr_r;
   logic [SRAM_DATA_WIDTH-1:0]   wr_data_r;
   logic                         busy_r;
   logic                         done_r;
   logic [7:0]                   byte_buf_r [ARRAY_SIZE][ARRAY_SIZE];
   logic [7:0]                   lane_byte_s [ARRAY_SIZE];
   logic [6:0]                   next_beat_s;
   logic [SRAM_DATA_WIDTH-1:0]   next_word_s;

   for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
      requant_lane u_lane (
         .v           (mul_outcome[i*OUTCOME_WIDTH +: OUTCOME_WIDTH]),
         .shift       (shift_r),
         .relu_en     (relu_r),
         .result_byte (lane_byte_s[i])
      );
   end

   // Word that the output register loads next: beat 0 on entry, else beat+1.
   always_comb begin
      next_word_s = '0;
      if (state_r == WRITE) begin
         next_beat_s = beat_r + 7'd1;
      end else begin
         next_beat_s = 7'd0;
      end
      // Byte 0 of a word sits in the most significant lane of wr_data.
      for (int b = 0; b < 8; b++) begin
         next_word_s[SRAM_DATA_WIDTH-1-8*b -: 8] =
            byte_buf_r[next_beat_s[6:2]][{next_beat_s[1:0], 3'(b)}];
      end
   end

   // Byte buffer capture: lane i carries column (k-i) mod 32 of row i.
   always_ff @(posedge clk) begin
      if (state_r == CAPTURE) begin
         for (int i = 0; i < ARRAY_SIZE; i++) begin
            byte_buf_r[i][cap_k_r - 5'(i)] <= lane_byte_s[i];
         end
      end
   end

   // Drain FSM, capture counter and write-port registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= IDLE;
         cap_k_r    <= 5'd0;
         beat_r     <= 7'd0;
         shift_r    <= 5'd0;
         relu_r     <= 1'b0;
         base_r     <= '0;
         wr_valid_r <= 1'b0;
         wr_addr_r  <= '0;
         wr_data_r  <= '0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            IDLE: begin
               // The done cycle is still IDLE; a start there is dropped.
               if (start && !done_r) begin
                  shift_r <= shift_amt;
                  relu_r  <= relu_en;
                  base_r  <= base_addr;
                  cap_k_r <= 5'd0;
                  busy_r  <= 1'b1;
                  state_r <= CAPTURE;
               end
            end
            CAPTURE: begin
               if (cap_k_r == 5'd31) begin
                  // Row 0 word 0 was fully captured by k=7, so it is safe
                  // to load it on the same edge that writes the last lanes.
                  cap_k_r    <= 5'd0;
                  beat_r     <= 7'd0;
                  wr_valid_r <= 1'b1;
                  wr_addr_r  <= base_r;
                  wr_data_r  <= next_word_s;
                  state_r    <= WRITE;
               end else begin
                  cap_k_r <= cap_k_r + 5'd1;
               end
            end
            WRITE: begin
               if (wr_valid_r && wr_ready) begin
                  if (beat_r == 7'd127) begin
                     wr_valid_r <= 1'b0;
                     busy_r     <= 1'b0;
                     done_r     <= 1'b1;
                     state_r    <= IDLE;
                  end else begin
                     beat_r    <= beat_r + 7'd1;
                     wr_addr_r <= wr_addr_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                     wr_data_r <= next_word_s;
                  end
               end
            end
            default: begin
               state_r    <= IDLE;
               cap_k_r    <= 5'd0;
               wr_valid_r <= 1'b0;
               busy_r     <= 1'b0;
            end
         endcase
      end
   end

   assign matrix_index = {1'b0, cap_k_r};
   assign wr_valid     = wr_valid_r;
   assign wr_addr      = wr_addr_r;
   assign wr_data      = wr_data_r;
   assign busy         = busy_r;
   assign done         = done_r;

endmodule

// File: doc/systolic_result_drain.md
Name: systolic_result_drain

Overview:
- Downstream stage of the 32x32 systolic multiply array.
- After the array finishes a tile, it walks the array's `matrix_index` output select from 0 to 31 and captures the 32-lane result bus each cycle.
- Each 41-bit accumulator is requantized to int8 (round, shift, optional ReLU, saturate) into a 32x32 byte buffer.
- The buffer is then streamed row-major to the output SRAM as 64-bit words over a valid/ready write port.

Parameters:
- ARRAY_SIZE, 32, array dimension (rows = columns).
- DATA_WIDTH, 18, array operand width.
- OUTCOME_WIDTH, 2*DATA_WIDTH+5 (41), width of one result lane.
- SRAM_DATA_WIDTH, 64, output word width (8 int8 elements).
- ADDR_WIDTH, 10, output SRAM address width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- start  in  1  single-cycle pulse: tile accumulation complete, begin drain.
- shift_amt  in  5  arithmetic right-shift for requantization; latched at start.
- relu_en  in  1  clamp negatives to 0; latched at start.
- base_addr  in  ADDR_WIDTH  first output word address; latched at start.
- matrix_index  out  6  result-select driven to the array.
- mul_outcome  in  ARRAY_SIZE*OUTCOME_WIDTH  array result bus; lane i is bits [i*41 +: 41].
- wr_valid  out  1  output word valid.
- wr_ready  in  1  SRAM accepts word.
- wr_addr  out  ADDR_WIDTH  output word address.
- wr_data  out  SRAM_DATA_WIDTH  packed int8 word.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse after the last word is accepted.

Behaviour:
- Reset values: matrix_index=0, wr_valid=0, wr_addr=0, wr_data=0, busy=0, done=0, state=IDLE. The byte buffer is not reset.
- States:
  - IDLE: wait for start. Start sampled at cycle T latches shift_amt, relu_en and base_addr, then goes to CAPTURE.
  - CAPTURE: cycles T+1..T+32; counter k runs 0..31.
  - WRITE: row r 0..31, word w 0..3.
  - IDLE again after done.
- CAPTURE:
  - matrix_index=k, driven from a register. mul_outcome is read combinationally in the same cycle.
  - Lane i holds result (row i, column (k-i) mod 32). Its requantized byte is written to buf[i][(k-i) mod 32] at the cycle edge.
  - matrix_index returns to 0 outside CAPTURE.
- Requantization, per 41-bit signed value v, with s = latched shift:
  - If s>0, t = (v + (1<<(s-1))) >>> s, in 42-bit arithmetic; otherwise t = v.
  - If relu_en and t<0, t = 0.
  - Saturate t to [-128,127].
- WRITE:
  - Beat (r,w): wr_addr = base_addr + 4r + w (modulo 2^ADDR_WIDTH, wraps silently).
  - wr_data bits [63-8b -: 8] = buf[r][8w+b], for b = 0..7.
  - First wr_valid at T+33.
  - wr_valid stays high, with addr and data stable, until wr_ready. The beat advances on valid&&ready.
  - wr_ready=0 stalls indefinitely without loss.
- Completion and latency:
  - 128 beats per tile. done is pulsed the cycle after the final handshake, and busy drops in that same cycle.
  - With wr_ready held at 1: last beat at T+160, done at T+161.
- Boundary conditions:
  - start while busy is ignored; a new drain is only possible once back in IDLE.
  - start in the same cycle as done is ignored.
  - rst mid-operation: next cycle returns to IDLE with all outputs at reset values. Buffer contents are discarded and no further writes occur.
  - wr_ready high while wr_valid=0 has no effect.
- Upstream contract: the array's accumulators must remain static during CAPTURE (alu_start low). The block does not check this.

Decomposition:
- Package systolic_pkg:
  - constants ARRAY_SIZE and OUTCOME_WIDTH;
  - the drain state enum (IDLE, CAPTURE, WRITE);
  - a saturating-requantize helper function.
- Sub-module requant_lane: combinational, one 41-bit lane to int8. Inputs v, shift, relu_en; output byte. Instantiated ARRAY_SIZE times in a generate loop.
- The FSM, counters, buffer and write port stay in systolic_result_drain.

Test Plan:
- Identity tile: model array with result(r,c) = r*32+c, shift=0, relu off, base 0, wr_ready=1.
  - Expect matrix_index 0..31 over T+1..T+32.
  - Expect 128 words at T+33..T+160; word (r,w) byte b = sat8(r*32+8w+b), so rows with r>=4 read 127.
  - Expect done pulse at T+161.
- Rounding and shift: all results 0x1_0000_0180 (41-bit), shift=8 -> every byte 127 (saturates). All results -384, shift=8 -> -1.5 rounds to -1, so every byte 0xFF.
- ReLU: alternating +50/-50 results, shift=0, relu_en=1 -> bytes alternate 0x32/0x00. With relu_en=0 -> 0x32/0xCE.
- Backpressure: wr_ready toggled 1-0-0-1 pseudo-randomly -> exactly 128 handshakes in address order base..base+127, data stable during every stall, done one cycle after the final handshake. With base_addr=1020, addresses wrap 1020..1023, then 0..123.
- Start while busy: second start at T+10 and T+100 -> no restart, same outputs as a single run, one done pulse.
- Mid-operation reset: rst at T+50 -> wr_valid=0 and busy=0 at T+51. A new start at T+55 completes a full, correct 128-beat drain.
